// File: rtl/hd44780_lcd_responder.sv
// hd44780_lcd_responder: device-side model of an HD44780-class 16x2 character LCD.
// Decodes controller transactions on the fall of EN, answers status and data reads on the
// shared bus, and exposes DDRAM and display state for checking.
// Optional feature macro: LCD_RESP_CGRAM_EN adds a 64 x 8 CGRAM. Without it, CGRAM data
// writes are dropped (AC still steps) and CGRAM data reads return 8'h00.
module hd44780_lcd_responder #(
    parameter int unsigned POR_CYCLES   = 16,
    parameter int unsigned EXEC_CYCLES  = 8,
    parameter int unsigned CLEAR_CYCLES = 96
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [7:0] LCD_DATA,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_ON,
    input  logic [6:0] disp_index,
    output logic [7:0] disp_char,
    output logic [6:0] addr_cnt,
    output logic       busy,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       proto_err
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StExec  = 2'd1;
    localparam logic [1:0] StClear = 2'd2;
    localparam logic [1:0] StPor   = 2'd3;

    localparam int unsigned CntW     = 16;
    localparam logic [6:0]  NumCells = 7'd80;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      clr_idx_q, clr_idx_d;
    logic            en_q, en_d;
    logic            rs_q, rs_d, rw_q, rw_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rd_word_q, rd_word_d;
    logic [6:0]      ac_q, ac_d;
    logic            inc_q, inc_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic            cg_sel_q, cg_sel_d, err_q, err_d;

    logic [7:0]      ddram [80];
    logic            dd_we;
    logic [6:0]      dd_waddr;
    logic [7:0]      dd_wdata;
`ifdef LCD_RESP_CGRAM_EN
    logic [7:0]      cgram [64];
    logic            cg_we;
`endif

    logic            en_eff, en_rise, en_fall;
    logic [7:0]      ram_rd;

    // DDRAM AC step: two 40-column lines based at 0x00 and 0x40
    function automatic logic [6:0] dd_step(input logic [6:0] ac, input logic up);
        logic [6:0] nxt;
        if (up) nxt = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
        else    nxt = (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
        return nxt;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up,
                                           input logic cg);
        logic [5:0] low;
        low = up ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1;
        return cg ? {1'b0, low} : dd_step(ac, up);
    endfunction

    function automatic logic [6:0] dd_index(input logic [6:0] ac);
        return ac[6] ? 7'd40 + {1'b0, ac[5:0]} : {1'b0, ac[5:0]};
    endfunction

    // EN edges are only seen while the panel is powered
    assign en_eff  = LCD_EN & LCD_ON;
    assign en_rise = en_eff & ~en_q;
    assign en_fall = en_q & ~LCD_EN & LCD_ON;
    assign busy    = (state_q != StIdle);

    // Cell addressed by AC, from whichever RAM is selected
    always_comb begin
        ram_rd = ddram[dd_index(ac_q)];
        if (cg_sel_q) begin
`ifdef LCD_RESP_CGRAM_EN
            ram_rd = cgram[ac_q[5:0]];
`else
            ram_rd = 8'h00;
`endif
        end
    end

    // Next state: busy timers, bus capture, read word, and transaction execution on EN fall
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        en_d      = en_eff;
        rs_d      = rs_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rd_word_d = rd_word_q;
        ac_d      = ac_q;
        inc_d     = inc_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        cg_sel_d  = cg_sel_q;
        err_d     = err_q;
        dd_we     = 1'b0;
        dd_waddr  = dd_index(ac_q);
        dd_wdata  = wdata_q;
`ifdef LCD_RESP_CGRAM_EN
        cg_we     = 1'b0;
`endif

        case (state_q)
            StPor, StExec: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StClear: begin
                // Sweep fills one cell per cycle; the countdown covers the sweep too
                if (clr_idx_q < NumCells) begin
                    dd_we     = 1'b1;
                    dd_waddr  = clr_idx_q;
                    dd_wdata  = 8'h20;
                    clr_idx_d = clr_idx_q + 7'd1;
                end
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: ;
        endcase

        if (en_eff) begin
            rs_d    = LCD_RS;
            rw_d    = LCD_RW;
            wdata_d = LCD_DATA;
        end
        if (en_rise) rd_word_d = LCD_RS ? ram_rd : {busy, ac_q};

        if (en_fall) begin
            if (rw_q) begin
                if (rs_q) begin
                    if (busy) err_d = 1'b1;
                    ac_d = ac_step(ac_q, inc_q, cg_sel_q);
                end
            end else if (busy) begin
                err_d = 1'b1;
            end else begin
                state_d = StExec;
                cnt_d   = CntW'(EXEC_CYCLES - 1);
                if (rs_q) begin
                    if (cg_sel_q) begin
`ifdef LCD_RESP_CGRAM_EN
                        cg_we = 1'b1;
`endif
                    end else begin
                        dd_we = 1'b1;
                    end
                    ac_d = ac_step(ac_q, inc_q, cg_sel_q);
                end else if (wdata_q[7]) begin
                    cg_sel_d = 1'b0;
                    ac_d     = (wdata_q[5:0] > 6'h27) ? {wdata_q[6], 6'h00} : wdata_q[6:0];
                end else if (wdata_q[6]) begin
                    cg_sel_d = 1'b1;
                    ac_d     = {1'b0, wdata_q[5:0]};
                end else if (wdata_q[5]) begin
                    if (!wdata_q[4]) err_d = 1'b1;
                end else if (wdata_q[4]) begin
                    if (!wdata_q[3]) ac_d = ac_step(ac_q, wdata_q[2], cg_sel_q);
                end else if (wdata_q[3]) begin
                    {disp_d, cur_d, blink_d} = wdata_q[2:0];
                end else if (wdata_q[2]) begin
                    inc_d = wdata_q[1];
                end else if (wdata_q[1]) begin
                    ac_d     = '0;
                    cg_sel_d = 1'b0;
                    cnt_d    = CntW'(CLEAR_CYCLES - 1);
                end else if (wdata_q[0]) begin
                    state_d   = StClear;
                    cnt_d     = CntW'(CLEAR_CYCLES - 1);
                    clr_idx_d = '0;
                    ac_d      = '0;
                    inc_d     = 1'b1;
                    cg_sel_d  = 1'b0;
                end
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StPor;
            cnt_q     <= CntW'(POR_CYCLES - 1);
            clr_idx_q <= '0;
            en_q      <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rd_word_q <= '0;
            ac_q      <= '0;
            inc_q     <= 1'b1;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            cg_sel_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            en_q      <= en_d;
            rs_q      <= rs_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rd_word_q <= rd_word_d;
            ac_q      <= ac_d;
            inc_q     <= inc_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            cg_sel_q  <= cg_sel_d;
            err_q     <= err_d;
        end
    end

    // DDRAM write port; contents survive reset, and reset stops a clear sweep in place
    always_ff @(posedge clk) begin
        if (dd_we && !reset) ddram[dd_waddr] <= dd_wdata;
    end

`ifdef LCD_RESP_CGRAM_EN
    // CGRAM write port, addressed by AC modulo 64
    always_ff @(posedge clk) begin
        if (cg_we && !reset) cgram[ac_q[5:0]] <= wdata_q;
    end
`endif

    assign LCD_DATA   = (LCD_EN && LCD_RW && LCD_ON) ? rd_word_q : 8'hzz;
    assign disp_char  = (disp_index < NumCells) ? ddram[disp_index] : 8'h00;
    assign addr_cnt   = ac_q;
    assign display_on = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign inc_mode   = inc_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// tb_hd44780_lcd_responder: scoreboard bench for the HD44780 responder. The driver applies
// directed and random bus transactions and pushes expected observations computed by a
// reference model over a linear 80-cell display; the monitor pops and compares them.
module tb_hd44780_lcd_responder;
    localparam int unsigned POR_C   = 16;
    localparam int unsigned EXEC_C  = 8;
    localparam int unsigned CLEAR_C = 96;

    localparam int KBus = 0, KAc = 1, KChar = 2, KErr = 3, KFlags = 4, KBusyLen = 5;

    logic       clk, reset;
    logic       en_drv, rs_drv, rw_drv, lcd_on;
    logic [7:0] data_drv;
    wire  [7:0] lcd_data;
    logic [6:0] disp_index;
    logic [7:0] disp_char;
    logic [6:0] addr_cnt;
    logic       busy, display_on, cursor_on, blink_on, inc_mode, proto_err;

    assign lcd_data = rw_drv ? 8'hzz : data_drv;

    hd44780_lcd_responder #(
        .POR_CYCLES  (POR_C),
        .EXEC_CYCLES (EXEC_C),
        .CLEAR_CYCLES(CLEAR_C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .LCD_DATA  (lcd_data),
        .LCD_EN    (en_drv),
        .LCD_RS    (rs_drv),
        .LCD_RW    (rw_drv),
        .LCD_ON    (lcd_on),
        .disp_index(disp_index),
        .disp_char (disp_char),
        .addr_cnt  (addr_cnt),
        .busy      (busy),
        .display_on(display_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .inc_mode  (inc_mode),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] exp;
    } item_t;

    item_t sb[$];
    logic  obs_valid;
    int    busy_len;
    int    n_vec, n_err;

    // Reference model: DDRAM as a linear 80-cell ring, CGRAM as a 64-entry ring
    logic [7:0] m_dd [80];
    bit         m_dd_known [80];
`ifdef LCD_RESP_CGRAM_EN
    logic [7:0] m_cgram [64];
    bit         m_cg_known [64];
`endif
    int m_pos, m_cg;
    bit m_cgsel, m_inc, m_disp, m_cur, m_blink, m_err;

    function automatic logic [6:0] model_ac();
        if (m_cgsel)    return 7'(m_cg);
        if (m_pos < 40) return 7'(m_pos);
        return 7'(64 + m_pos - 40);
    endfunction

    function automatic void model_move(input bit fwd);
        if (m_cgsel) m_cg  = fwd ? (m_cg + 1) % 64 : (m_cg + 63) % 64;
        else         m_pos = fwd ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
    endfunction

    function automatic void model_write(input bit rs, input logic [7:0] d, input bit accepted);
        int col;
        if (!accepted) begin
            m_err = 1;
            return;
        end
        if (rs) begin
            if (!m_cgsel) begin
                m_dd[m_pos] = d;
                m_dd_known[m_pos] = 1;
            end
`ifdef LCD_RESP_CGRAM_EN
            else begin
                m_cgram[m_cg] = d;
                m_cg_known[m_cg] = 1;
            end
`endif
            model_move(m_inc);
        end else if (d[7]) begin
            col = int'(d[5:0]);
            if (col > 39) col = 0;
            m_cgsel = 0;
            m_pos = (d[6] ? 40 : 0) + col;
        end else if (d[6]) begin
            m_cgsel = 1;
            m_cg = int'(d[5:0]);
        end else if (d[5]) begin
            if (!d[4]) m_err = 1;
        end else if (d[4]) begin
            if (!d[3]) model_move(d[2]);
        end else if (d[3]) begin
            m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
        end else if (d[2]) begin
            m_inc = d[1];
        end else if (d[1]) begin
            m_pos = 0; m_cgsel = 0;
        end else if (d[0]) begin
            for (int i = 0; i < 80; i++) begin
                m_dd[i] = 8'h20;
                m_dd_known[i] = 1;
            end
            m_pos = 0; m_inc = 1; m_cgsel = 0;
        end
    endfunction

    // Monitor: compares the oldest expectation whenever the driver flags an observation
    always @(negedge clk) begin
        if (obs_valid) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL scoreboard: observation with empty queue, required an entry");
            end else begin
                item_t it;
                logic [7:0] act;
                it = sb.pop_front();
                case (it.kind)
                    KBus:    act = lcd_data;
                    KAc:     act = {1'b0, addr_cnt};
                    KChar:   act = disp_char;
                    KErr:    act = {7'b0, proto_err};
                    KFlags:  act = {4'b0, display_on, cursor_on, blink_on, inc_mode};
                    default: act = busy_len[7:0];
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, required %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic observe(input string name, input int kind, input logic [7:0] exp,
                           input logic [6:0] idx);
        item_t it;
        it.name = name; it.kind = kind; it.exp = exp;
        sb.push_back(it);
        disp_index = idx;
        obs_valid = 1'b1;
        @(posedge clk); #1;
        obs_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic bus_write(input bit rs, input logic [7:0] d);
        @(posedge clk); #1;
        rs_drv = rs; rw_drv = 1'b0; data_drv = d; en_drv = 1'b1;
        @(posedge clk); #1;
        en_drv = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input bit rs, input bit chk, input logic [7:0] exp,
                            input string name);
        item_t it;
        @(posedge clk); #1;
        rs_drv = rs; rw_drv = 1'b1; en_drv = 1'b1;
        @(posedge clk); #1;
        if (chk) begin
            it.name = name; it.kind = KBus; it.exp = exp;
            sb.push_back(it);
            obs_valid = 1'b1;
        end
        @(posedge clk); #1;
        obs_valid = 1'b0; en_drv = 1'b0;
        @(posedge clk); #1;
        rw_drv = 1'b0;
    endtask

    task automatic wr(input bit rs, input logic [7:0] d);
        wait_idle();
        bus_write(rs, d);
        model_write(rs, d, 1'b1);
    endtask

    task automatic data_read(input string name);
        logic [7:0] exp;
        bit known;
        if (m_cgsel) begin
`ifdef LCD_RESP_CGRAM_EN
            exp = m_cgram[m_cg]; known = m_cg_known[m_cg];
`else
            exp = 8'h00; known = 1;
`endif
        end else begin
            exp = m_dd[m_pos]; known = m_dd_known[m_pos];
        end
        wait_idle();
        bus_read(1'b1, known, exp, name);
        model_move(m_inc);
    endtask

    task automatic status_read(input string name);
        wait_idle();
        bus_read(1'b0, 1'b1, {1'b0, model_ac()}, name);
    endtask

    task automatic check_state(input string name);
        observe({name, "_ac"}, KAc, {1'b0, model_ac()}, 7'd0);
        observe({name, "_flags"}, KFlags, {4'b0, m_disp, m_cur, m_blink, m_inc}, 7'd0);
        observe({name, "_err"}, KErr, {7'b0, m_err}, 7'd0);
    endtask

    task automatic check_chars(input string name);
        for (int i = 0; i < 80; i++)
            if (m_dd_known[i]) observe(name, KChar, m_dd[i], 7'(i));
    endtask

    // Overall time bound
    initial begin
        #600000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        int op;
        n_vec = 0; n_err = 0; busy_len = 0;
        obs_valid = 1'b0; disp_index = '0;
        en_drv = 1'b0; rs_drv = 1'b0; rw_drv = 1'b0; data_drv = '0; lcd_on = 1'b1;
        for (int i = 0; i < 80; i++) m_dd_known[i] = 0;
`ifdef LCD_RESP_CGRAM_EN
        for (int i = 0; i < 64; i++) m_cg_known[i] = 0;
`endif
        m_pos = 0; m_cg = 0; m_cgsel = 0; m_inc = 1;
        m_disp = 0; m_cur = 0; m_blink = 0; m_err = 0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // T1: busy status during power-on, clear status afterwards
        bus_read(1'b0, 1'b1, {1'b1, model_ac()}, "por_status");
        check_state("reset");
        status_read("idle_status");

        // T2: init sequence and two characters
        wr(0, 8'h38); wr(0, 8'h0C); wr(0, 8'h06); wr(0, 8'h80);
        wr(1, 8'h48); wr(1, 8'h69);
        observe("t2_char0", KChar, m_dd[0], 7'd0);
        observe("t2_char1", KChar, m_dd[1], 7'd1);
        check_state("t2");

        // Panel off: EN edges ignored
        wait_idle();
        lcd_on = 1'b0;
        bus_write(0, 8'h0F);
        lcd_on = 1'b1;
        check_state("off");

        // T3: line wrap boundaries
        wr(0, 8'hA7); wr(1, 8'h58);
        observe("t3_ac_wrap1", KAc, {1'b0, model_ac()}, 7'd0);
        wr(0, 8'hE7); wr(1, 8'h59);
        observe("t3_ac_wrap2", KAc, {1'b0, model_ac()}, 7'd0);
        wr(0, 8'h04); wr(1, 8'h5A);
        observe("t3_ac_dec", KAc, {1'b0, model_ac()}, 7'd0);
        observe("t3_c39", KChar, m_dd[39], 7'd39);
        observe("t3_c79", KChar, m_dd[79], 7'd79);
        observe("t3_c0", KChar, m_dd[0], 7'd0);

        // Busy durations for a plain command, clear and home
        wr(0, 8'h06);
        measure_busy(busy_len);
        observe("exec_busy", KBusyLen, 8'(EXEC_C), 7'd0);
        wr(0, 8'h01);
        measure_busy(busy_len);
        observe("clear_busy", KBusyLen, 8'(CLEAR_C), 7'd0);
        check_chars("clear_char");
        wr(0, 8'h02);
        measure_busy(busy_len);
        observe("home_busy", KBusyLen, 8'(CLEAR_C), 7'd0);

        // T4: write while clearing is dropped and flagged
        wr(0, 8'h01);
        bus_write(1, 8'h51);
        model_write(1, 8'h51, 1'b0);
        observe("busy_write_err", KErr, {7'b0, m_err}, 7'd0);
        wait_idle();
        observe("busy_write_drop", KChar, m_dd[0], 7'd0);

        // T5: second line write and read-back
        wr(0, 8'hC0); wr(1, 8'h41); wr(0, 8'hC0);
        data_read("t5_read");
        observe("t5_ac", KAc, {1'b0, model_ac()}, 7'd0);
        status_read("t5_status");

        // T6: CGRAM write and read-back
        wr(0, 8'h48); wr(1, 8'h1F); wr(0, 8'h48);
        data_read("t6_cg_read");
        observe("t6_ac", KAc, {1'b0, model_ac()}, 7'd0);

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            r = 8'($urandom);
            case (op)
                0:       wr(0, {1'b1, r[6:0]});
                1, 2:    wr(1, r);
                3:       data_read("rnd_read");
                4:       status_read("rnd_status");
                5:       wr(0, {6'b000001, r[1:0]});
                6:       wr(0, {5'b00001, r[2:0]});
                7:       wr(0, {4'b0001, r[3:0]});
                8:       wr(0, {2'b01, r[5:0]});
                default: begin
                    if (r[7:5] == 3'd0) begin
                        wr(0, 8'h01);
                        bus_write(1, r);
                        model_write(1, r, 1'b0);
                    end else begin
                        wr(0, {4'b0011, r[3:0]});
                    end
                end
            endcase
            if (it % 10 == 9) check_state("rnd");
        end
        wait_idle();
        check_chars("final_char");
        check_state("final");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
